atm_session_ctrl: RTL and testbench

Session controller for the ATM card datapath. Sequences one customer session from card insertion through password verification, transaction execution and card ejection, and drives the card handler's `op_done` / `updated_balance` write-back port. Locks a card after repeated wrong passwords. Sits between the front-panel/keypad logic and the card handler store.

---
 rtl/atm_session_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card insertion, password check, transactions, ejection and lockout.
// Define ATM_TIMEOUT_EN to compile in the WAIT_PSW/MENU inactivity timeout.
module atm_session_ctrl #(
    parameter int card_width     = 3,
    parameter int balance_width  = 20,
    parameter int users_num      = 7,
    parameter int max_tries      = 3,
    parameter int timeout_cycles = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     card_in,
    input  logic [card_width-1:0]    card_number,
    input  logic                     psw_valid,
    input  logic                     wrong_psw,
    input  logic [balance_width-1:0] balance,
    input  logic                     op_valid,
    input  logic [1:0]               op_code,
    input  logic [balance_width-1:0] amount,
    output logic                     op_done,
    output logic [balance_width-1:0] updated_balance,
    output logic [balance_width-1:0] disp_balance,
    output logic                     eject,
    output logic                     locked,
    output logic                     err,
    output logic [2:0]               state
);

    localparam int TRY_W = $clog2(max_tries + 1);
    localparam logic [TRY_W-1:0]      TRY_ONE = TRY_W'(1);
    localparam logic [TRY_W-1:0]      TRY_MAX = TRY_W'(max_tries);
    localparam logic [card_width:0]   USERS   = (card_width + 1)'(users_num);
    localparam logic [1:0] OP_INQ  = 2'b00;
    localparam logic [1:0] OP_DEP  = 2'b01;
    localparam logic [1:0] OP_EXIT = 2'b11;

    if (max_tries < 1 || timeout_cycles < 1 || users_num > (1 << card_width)) begin : g_param_check
        $error("atm_session_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PSW = 3'd1,
        S_CHECK    = 3'd2,
        S_MENU     = 3'd3,
        S_EXEC     = 3'd4,
        S_EJECT    = 3'd5,
        S_LOCKOUT  = 3'd6
    } state_t;

    state_t                     st;
    logic [balance_width-1:0]   cur_bal;
    logic [TRY_W-1:0]           tries;
    logic [TRY_W-1:0]           tries_nxt;
    logic [users_num-1:0]       lock_bits;
    logic [card_width-1:0]      card_p0;
    logic [1:0]                 op_code_p0;
    logic [balance_width-1:0]   amount_p0;
    logic                       card_ok;

`ifdef ATM_TIMEOUT_EN
    localparam int TMR_W = $clog2(timeout_cycles + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(timeout_cycles - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    logic [TMR_W-1:0] timer;
`endif

    function automatic logic dep_overflows(input logic [balance_width-1:0] bal,
                                           input logic [balance_width-1:0] amt);
        logic [balance_width:0] sum;
        sum = {1'b0, bal} + {1'b0, amt};
        return sum[balance_width];
    endfunction

    function automatic logic wd_short(input logic [balance_width-1:0] bal,
                                      input logic [balance_width-1:0] amt);
        return amt > bal;
    endfunction

    assign card_ok         = {1'b0, card_number} < USERS;
    assign tries_nxt       = tries + TRY_ONE;
    assign updated_balance = cur_bal;
    assign state           = st;

    // Session data latches: card id while idle, transaction request while in MENU
    always_ff @(posedge clk) begin
        if (st == S_IDLE) card_p0 <= card_number;
        if (st == S_MENU && op_valid) begin
            op_code_p0 <= op_code;
            amount_p0  <= amount;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st           <= S_IDLE;
            cur_bal      <= '0;
            disp_balance <= '0;
            tries        <= '0;
            lock_bits    <= '0;
            op_done      <= 1'b0;
            err          <= 1'b0;
            eject        <= 1'b0;
            locked       <= 1'b0;
`ifdef ATM_TIMEOUT_EN
            timer        <= '0;
`endif
        end else begin
            op_done <= 1'b0;
            err     <= 1'b0;
            eject   <= 1'b0;
`ifdef ATM_TIMEOUT_EN
            timer   <= '0;
`endif
            // Card removal aborts any session; a pending EXEC result is dropped
            if (st != S_IDLE && !card_in) begin
                st     <= S_IDLE;
                locked <= 1'b0;
            end else begin
                case (st)
                    S_IDLE: begin
                        cur_bal <= balance;
                        if (card_in) begin
                            if (!card_ok) begin
                                st    <= S_EJECT;
                                eject <= 1'b1;
                            end else if (lock_bits[card_number]) begin
                                st     <= S_LOCKOUT;
                                eject  <= 1'b1;
                                locked <= 1'b1;
                            end else begin
                                st    <= S_WAIT_PSW;
                                tries <= '0;
                            end
                        end
                    end
                    S_WAIT_PSW: begin
                        if (psw_valid) st <= S_CHECK;
`ifdef ATM_TIMEOUT_EN
                        else if (timer == TMR_LAST) begin
                            st    <= S_EJECT;
                            eject <= 1'b1;
                        end else timer <= timer + TMR_ONE;
`endif
                    end
                    S_CHECK: begin
                        if (!wrong_psw) begin
                            cur_bal <= balance;
                            st      <= S_MENU;
                        end else begin
                            tries <= tries_nxt;
                            if (tries_nxt == TRY_MAX) begin
                                lock_bits[card_p0] <= 1'b1;
                                st     <= S_LOCKOUT;
                                eject  <= 1'b1;
                                locked <= 1'b1;
                            end else begin
                                st <= S_WAIT_PSW;
                            end
                        end
                    end
                    S_MENU: begin
                        if (op_valid) begin
                            if (op_code == OP_EXIT) begin
                                st    <= S_EJECT;
                                eject <= 1'b1;
                            end else begin
                                st <= S_EXEC;
                            end
                        end
`ifdef ATM_TIMEOUT_EN
                        else if (timer == TMR_LAST) begin
                            st    <= S_EJECT;
                            eject <= 1'b1;
                        end else timer <= timer + TMR_ONE;
`endif
                    end
                    S_EXEC: begin
                        st <= S_MENU;
                        if (op_code_p0 == OP_INQ) begin
                            disp_balance <= cur_bal;
                            op_done      <= 1'b1;
                        end else if (op_code_p0 == OP_DEP) begin
                            if (dep_overflows(cur_bal, amount_p0)) err <= 1'b1;
                            else begin
                                cur_bal <= cur_bal + amount_p0;
                                op_done <= 1'b1;
                            end
                        end else begin
                            if (wd_short(cur_bal, amount_p0)) err <= 1'b1;
                            else begin
                                cur_bal <= cur_bal - amount_p0;
                                op_done <= 1'b1;
                            end
                        end
                    end
                    default: ; // EJECT and LOCKOUT hold until the card is pulled
                endcase
            end
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Randomized self-checking bench for atm_session_ctrl against a transaction-level model.
module tb_atm_session_ctrl;

    localparam int CW = 3;
    localparam int BW = 20;
    localparam int UN = 7;
    localparam int MT = 3;
    localparam int TO = 16;
    localparam longint MAXBAL = (longint'(1) << BW) - 1;

    localparam int ST_IDLE  = 0;
    localparam int ST_WAIT  = 1;
    localparam int ST_CHECK = 2;
    localparam int ST_MENU  = 3;
    localparam int ST_EXEC  = 4;
    localparam int ST_EJECT = 5;
    localparam int ST_LOCK  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          card_in;
    logic [CW-1:0] card_number;
    logic          psw_valid;
    logic          wrong_psw;
    logic [BW-1:0] balance;
    logic          op_valid;
    logic [1:0]    op_code;
    logic [BW-1:0] amount;
    logic          op_done;
    logic [BW-1:0] updated_balance;
    logic [BW-1:0] disp_balance;
    logic          eject;
    logic          locked;
    logic          err;
    logic [2:0]    state;

    // Card handler store and model state
    logic [BW-1:0] store [0:(1<<CW)-1];
    bit            lock_m [0:(1<<CW)-1];
    int            tries_m;
    longint        exp_bal;
    logic [BW-1:0] exp_disp;
    int            checks;
    int            failures;

    assign balance = store[card_number];

    atm_session_ctrl #(
        .card_width(CW), .balance_width(BW), .users_num(UN),
        .max_tries(MT), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .card_number(card_number),
        .psw_valid(psw_valid), .wrong_psw(wrong_psw), .balance(balance),
        .op_valid(op_valid), .op_code(op_code), .amount(amount),
        .op_done(op_done), .updated_balance(updated_balance), .disp_balance(disp_balance),
        .eject(eject), .locked(locked), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check_val("rst_state", 32'(state), ST_IDLE);
        check_val("rst_op_done", 32'(op_done), 0);
        check_val("rst_err", 32'(err), 0);
        check_val("rst_eject", 32'(eject), 0);
        check_val("rst_locked", 32'(locked), 0);
        check_val("rst_upd_bal", 32'(updated_balance), 0);
        check_val("rst_disp_bal", 32'(disp_balance), 0);
    endtask

    task automatic do_reset();
        card_in   = 1'b0;
        psw_valid = 1'b0;
        op_valid  = 1'b0;
        rst       = 1'b0;
        #2;
        check_reset_vals();
        tick();
        check_reset_vals();
        rst = 1'b1;
        for (int i = 0; i < (1 << CW); i++) lock_m[i] = 1'b0;
        exp_disp = '0;
        tick();
    endtask

    // res: 0 = waiting for password, 1 = card refused
    task automatic card_insert(input int card, output int res);
        card_number = CW'(card);
        card_in     = 1'b1;
        tick();
        if (card >= UN) begin
            check_val("ins_bad_state", 32'(state), ST_EJECT);
            check_val("ins_bad_eject", 32'(eject), 1);
            tick();
            check_val("ins_bad_eject_pulse", 32'(eject), 0);
            res = 1;
        end else if (lock_m[card]) begin
            check_val("ins_lock_state", 32'(state), ST_LOCK);
            check_val("ins_lock_eject", 32'(eject), 1);
            check_val("ins_lock_locked", 32'(locked), 1);
            tick();
            check_val("ins_lock_eject_pulse", 32'(eject), 0);
            check_val("ins_lock_level", 32'(locked), 1);
            res = 1;
        end else begin
            check_val("ins_state", 32'(state), ST_WAIT);
            check_val("ins_eject", 32'(eject), 0);
            tries_m = 0;
            res = 0;
        end
    endtask

    task automatic card_remove();
        card_in = 1'b0;
        tick();
        check_val("rm_state", 32'(state), ST_IDLE);
        check_val("rm_locked", 32'(locked), 0);
        tick();
        check_val("rm_idle_bal", 32'(updated_balance), 32'(store[card_number]));
    endtask

    // res: 0 = retry, 1 = in MENU, 2 = locked out
    task automatic enter_psw(input bit wrong, output int res);
        int card;
        card      = int'(card_number);
        psw_valid = 1'b1;
        tick();
        psw_valid = 1'b0;
        check_val("psw_check_state", 32'(state), ST_CHECK);
        wrong_psw = wrong;
        tick();
        wrong_psw = 1'b0;
        if (!wrong) begin
            exp_bal = longint'(store[card]);
            check_val("psw_ok_state", 32'(state), ST_MENU);
            check_val("psw_ok_bal", 32'(updated_balance), 32'(exp_bal));
            res = 1;
        end else begin
            tries_m++;
            if (tries_m >= MT) begin
                lock_m[card] = 1'b1;
                check_val("psw_lock_state", 32'(state), ST_LOCK);
                check_val("psw_lock_eject", 32'(eject), 1);
                check_val("psw_lock_locked", 32'(locked), 1);
                tick();
                check_val("psw_lock_eject_pulse", 32'(eject), 0);
                res = 2;
            end else begin
                check_val("psw_retry_state", 32'(state), ST_WAIT);
                res = 0;
            end
        end
    endtask

    task automatic do_op(input int code, input logic [BW-1:0] amt, input bit abort, output bit ended);
        bit     exp_done;
        bit     exp_err;
        longint a;
        a        = longint'(amt);
        ended    = 1'b0;
        op_valid = 1'b1;
        op_code  = 2'(code);
        amount   = amt;
        tick();
        op_valid = 1'b0;
        if (code == 3) begin
            check_val("exit_state", 32'(state), ST_EJECT);
            check_val("exit_eject", 32'(eject), 1);
            tick();
            check_val("exit_eject_pulse", 32'(eject), 0);
            ended = 1'b1;
            return;
        end
        check_val("exec_state", 32'(state), ST_EXEC);
        check_val("exec_no_early_done", 32'(op_done), 0);
        if (abort) begin
            card_in = 1'b0;
            tick();
            check_val("abort_state", 32'(state), ST_IDLE);
            check_val("abort_done", 32'(op_done), 0);
            check_val("abort_err", 32'(err), 0);
            ended = 1'b1;
            return;
        end
        tick();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (code == 0) begin
            exp_done = 1'b1;
            exp_disp = BW'(exp_bal);
        end else if (code == 1) begin
            if (exp_bal + a > MAXBAL) exp_err = 1'b1;
            else begin
                exp_bal  = exp_bal + a;
                exp_done = 1'b1;
            end
        end else begin
            if (a > exp_bal) exp_err = 1'b1;
            else begin
                exp_bal  = exp_bal - a;
                exp_done = 1'b1;
            end
        end
        if (exp_done) store[card_number] = BW'(exp_bal);
        check_val("op_done", 32'(op_done), 32'(exp_done));
        check_val("op_err", 32'(err), 32'(exp_err));
        check_val("op_upd_bal", 32'(updated_balance), 32'(exp_bal));
        check_val("op_disp_bal", 32'(disp_balance), 32'(exp_disp));
        check_val("op_back_menu", 32'(state), ST_MENU);
        tick();
        check_val("op_done_pulse", 32'(op_done), 0);
        check_val("op_err_pulse", 32'(err), 0);
    endtask

    function automatic logic [BW-1:0] pick_amt();
        longint b;
        b = exp_bal;
        case ($urandom_range(0, 5))
            0:       return BW'($urandom);
            1:       return BW'(b);
            2:       return BW'(b + 1);
            3:       return BW'(MAXBAL - b);
            4:       return BW'(MAXBAL - b + 1);
            default: return BW'($urandom_range(0, 999));
        endcase
    endfunction

    initial begin
        int r;
        bit e;
        int ej;
        checks      = 0;
        failures    = 0;
        exp_disp    = '0;
        exp_bal     = 0;
        tries_m     = 0;
        card_in     = 1'b0;
        card_number = '0;
        psw_valid   = 1'b0;
        wrong_psw   = 1'b0;
        op_valid    = 1'b0;
        op_code     = '0;
        amount      = '0;
        rst         = 1'b0;
        for (int i = 0; i < (1 << CW); i++) begin
            store[i]  = BW'($urandom);
            lock_m[i] = 1'b0;
        end
        store[2] = 20'd500;
        store[3] = 20'd1234;
        store[4] = 20'd100;
        store[5] = 20'hFFFF0;
        do_reset();

        card_insert(2, r); enter_psw(1'b0, r);
        do_op(2, 20'd200, 1'b0, e);
        check_val("withdraw_300", 32'(updated_balance), 300);
        card_remove();

        card_insert(4, r); enter_psw(1'b0, r);
        do_op(2, 20'd150, 1'b0, e);
        check_val("overdraw_keep_100", 32'(updated_balance), 100);
        card_remove();

        card_insert(5, r); enter_psw(1'b0, r);
        do_op(1, 20'h20, 1'b0, e);
        do_op(1, 20'hF, 1'b0, e);
        check_val("deposit_to_max", 32'(updated_balance), 32'h000F_FFFF);
        do_op(0, 20'd0, 1'b0, e);
        check_val("inquiry_disp", 32'(disp_balance), 32'h000F_FFFF);
        do_op(2, 20'd0, 1'b0, e);
        card_remove();

        card_insert(3, r);
        op_valid = 1'b1; op_code = 2'b10; amount = 20'd5;
        tick();
        op_valid = 1'b0;
        check_val("opv_ignored_state", 32'(state), ST_WAIT);
        tick();
        check_val("opv_ignored_done", 32'(op_done), 0);
        enter_psw(1'b0, r);
        op_valid = 1'b1; op_code = 2'b10; amount = 20'd1; card_in = 1'b0;
        tick();
        op_valid = 1'b0;
        check_val("race_state", 32'(state), ST_IDLE);
        tick();
        check_val("race_no_done", 32'(op_done), 0);
        card_remove();

        card_insert(3, r); enter_psw(1'b0, r);
        do_op(1, 20'd10, 1'b1, e);
        card_remove();

        card_insert(2, r);
        for (int i = 0; i < MT; i++) enter_psw(1'b1, r);
        check_val("lock_after_tries", r, 2);
        card_remove();
        card_insert(2, r);
        check_val("relock_refused", r, 1);
        card_remove();
        card_insert(3, r); enter_psw(1'b0, r);
        check_val("other_card_ok", 32'(state), ST_MENU);
        card_remove();

        card_insert(7, r);
        card_remove();

        card_insert(3, r); enter_psw(1'b0, r);
        do_op(0, 20'd0, 1'b0, e);
        do_reset();
        card_insert(2, r);
        check_val("unlock_by_reset", r, 0);
        card_remove();

        card_insert(3, r); enter_psw(1'b0, r);
`ifdef ATM_TIMEOUT_EN
        repeat (TO - 1) tick();
        check_val("tmo_not_yet", 32'(state), ST_MENU);
        tick();
        check_val("tmo_state", 32'(state), ST_EJECT);
        check_val("tmo_eject", 32'(eject), 1);
`else
        ej = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (eject) ej++;
        end
        check_val("no_tmo_eject", ej, 0);
        check_val("no_tmo_state", 32'(state), ST_MENU);
`endif
        card_remove();

        for (int s = 0; s < 60; s++) begin
            int pr;
            int nops;
            int code;
            bit ended;
            if (s % 15 == 14) do_reset();
            card_insert($urandom_range(0, 7), r);
            if (r != 0) begin
                card_remove();
                continue;
            end
            pr = 0;
            while (pr == 0) enter_psw($urandom_range(0, 3) == 0, pr);
            if (pr == 2) begin
                card_remove();
                continue;
            end
            nops  = $urandom_range(1, 6);
            ended = 1'b0;
            for (int k = 0; k < nops && !ended; k++) begin
                repeat ($urandom_range(0, 3)) tick();
                code = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                do_op(code, pick_amt(), $urandom_range(0, 9) == 0, ended);
            end
            card_remove();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
